// File: rtl/npu_pkg.sv
// Shared constants, FSM state type and window geometry helpers for the NPU
// image-RAM readers.
package npu_pkg;

    localparam int PIX_W   = 8;
    localparam int KERNEL  = 3;
    localparam int WIN_PIX = KERNEL * KERNEL;
    localparam int WIN_W   = WIN_PIX * PIX_W;

    localparam int POS_W = 5;
    localparam int K_W   = 3;
    localparam int P_W   = 4;

    localparam logic [K_W-1:0] K_LAST = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Window pixel index p = 3*dr + dc, split back into its row/column offsets.
    function automatic logic [1:0] pix_dr(input logic [P_W-1:0] p);
        logic [1:0] dr;
        case (p)
            4'd0, 4'd1, 4'd2: dr = 2'd0;
            4'd3, 4'd4, 4'd5: dr = 2'd1;
            default:          dr = 2'd2;
        endcase
        return dr;
    endfunction

    function automatic logic [1:0] pix_dc(input logic [P_W-1:0] p);
        logic [1:0] dc;
        case (p)
            4'd0, 4'd3, 4'd6: dc = 2'd0;
            4'd1, 4'd4, 4'd7: dc = 2'd1;
            default:          dc = 2'd2;
        endcase
        return dc;
    endfunction

endpackage

// File: rtl/win_addr_gen.sv
// Maps a window position and fetch step to the two RAM read addresses.
// Step k fetches pixels 2k and 2k+1; the final step repeats pixel 8 on port 2.
module win_addr_gen
    import npu_pkg::*;
#(
    parameter int COLS   = 28,
    parameter int ADDR_W = 10
) (
    input  logic              en_i,
    input  logic [POS_W-1:0]  row_i,
    input  logic [POS_W-1:0]  col_i,
    input  logic [K_W-1:0]    k_i,
    output logic [ADDR_W-1:0] addr1_o,
    output logic [ADDR_W-1:0] addr2_o
);

    logic [P_W-1:0] p1;
    logic [P_W-1:0] p2;

    function automatic logic [ADDR_W-1:0] pix_addr(
        input logic [POS_W-1:0] row,
        input logic [POS_W-1:0] col,
        input logic [P_W-1:0]   p
    );
        logic [ADDR_W-1:0] r_abs;
        logic [ADDR_W-1:0] c_abs;
        r_abs = ADDR_W'(row) + ADDR_W'(pix_dr(p));
        c_abs = ADDR_W'(col) + ADDR_W'(pix_dc(p));
        return r_abs * ADDR_W'(COLS) + c_abs;
    endfunction

    always_comb begin
        p1 = {k_i, 1'b0};
        p2 = (k_i == K_LAST) ? p1 : p1 + 4'd1;
    end

    assign addr1_o = en_i ? pix_addr(row_i, col_i, p1) : '0;
    assign addr2_o = en_i ? pix_addr(row_i, col_i, p2) : '0;

endmodule

// File: rtl/conv_window_reader.sv
// Sweeps every 3x3 stride-1 window of the image RAM in raster order and
// streams each one as a 72-bit word over valid/ready.
//
// state | meaning
// IDLE  | waiting for start; read addresses parked at 0
// FETCH | k = 0..4, two pixels per cycle captured into the window register
// HOLD  | window presented with win_valid=1 until the consumer accepts it
module conv_window_reader
    import npu_pkg::*;
#(
    parameter int ROWS   = 28,
    parameter int COLS   = 28,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    input  logic [PIX_W-1:0]  data_in1,
    input  logic [PIX_W-1:0]  data_in2,
    output logic [WIN_W-1:0]  win_data,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [POS_W-1:0]  out_row,
    output logic [POS_W-1:0]  out_col,
    output logic              busy,
    output logic              done
);

    localparam logic [POS_W-1:0] ROW_LAST = POS_W'(ROWS - KERNEL);
    localparam logic [POS_W-1:0] COL_LAST = POS_W'(COLS - KERNEL);

    state_e             state_q;
    logic [POS_W-1:0]   row_q;
    logic [POS_W-1:0]   col_q;
    logic [K_W-1:0]     k_q;
    logic [WIN_W-1:0]   win_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;

    logic [POS_W-1:0]   row_d;
    logic [POS_W-1:0]   col_d;
    logic               last_win;

    always_comb begin
        row_d    = row_q;
        col_d    = col_q + 5'd1;
        last_win = (row_q == ROW_LAST) && (col_q == COL_LAST);
        if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            k_q     <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FETCH;
                        row_q   <= '0;
                        col_q   <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                FETCH: begin
                    // Port 2 data on the last step is a repeat of pixel 8 and is dropped.
                    case (k_q)
                        3'd0: begin
                            win_q[0*PIX_W +: PIX_W] <= data_in1;
                            win_q[1*PIX_W +: PIX_W] <= data_in2;
                        end
                        3'd1: begin
                            win_q[2*PIX_W +: PIX_W] <= data_in1;
                            win_q[3*PIX_W +: PIX_W] <= data_in2;
                        end
                        3'd2: begin
                            win_q[4*PIX_W +: PIX_W] <= data_in1;
                            win_q[5*PIX_W +: PIX_W] <= data_in2;
                        end
                        3'd3: begin
                            win_q[6*PIX_W +: PIX_W] <= data_in1;
                            win_q[7*PIX_W +: PIX_W] <= data_in2;
                        end
                        3'd4: begin
                            win_q[8*PIX_W +: PIX_W] <= data_in1;
                        end
                        default: ;
                    endcase
                    if (k_q == K_LAST) begin
                        state_q <= HOLD;
                        k_q     <= '0;
                        valid_q <= 1'b1;
                    end else begin
                        k_q <= k_q + 3'd1;
                    end
                end
                HOLD: begin
                    if (win_ready) begin
                        valid_q <= 1'b0;
                        if (last_win) begin
                            state_q <= IDLE;
                            row_q   <= '0;
                            col_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                            row_q   <= row_d;
                            col_q   <= col_d;
                            k_q     <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    win_addr_gen #(
        .COLS   (COLS),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .en_i    (state_q == FETCH),
        .row_i   (row_q),
        .col_i   (col_q),
        .k_i     (k_q),
        .addr1_o (rd_addr1),
        .addr2_o (rd_addr2)
    );

    assign win_data  = win_q;
    assign win_valid = valid_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_window_reader.sv
// Directed bench for conv_window_reader with a RAM model where ram[a] = a[7:0].
module tb_conv_window_reader;

    localparam int ROWS   = 28;
    localparam int COLS   = 28;
    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [7:0]        data_in1;
    logic [7:0]        data_in2;
    logic [71:0]       win_data;
    logic              win_valid;
    logic              win_ready;
    logic [4:0]        out_row;
    logic [4:0]        out_col;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    conv_window_reader #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .data_in1  (data_in1),
        .data_in2  (data_in2),
        .win_data  (win_data),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .out_row   (out_row),
        .out_col   (out_col),
        .busy      (busy),
        .done      (done)
    );

    assign data_in1 = rd_addr1[7:0];
    assign data_in2 = rd_addr2[7:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [ADDR_W-1:0] exp_addr(input int r, input int c, input int p);
        int a;
        a = (r + p / 3) * COLS + c + p % 3;
        return a[ADDR_W-1:0];
    endfunction

    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] w;
        logic [ADDR_W-1:0] a;
        w = '0;
        for (int p = 0; p < 9; p++) begin
            a = exp_addr(r, c, p);
            w[8*p +: 8] = a[7:0];
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] outs_vec();
        return 128'({win_data, rd_addr1, rd_addr2, out_row, out_col, win_valid, busy, done});
    endfunction

    // Called at a negedge; waits for the window, optionally stalls, then lets it be accepted.
    task automatic accept_window(input int r, input int c, input int stall, output int wait_cyc);
        int w;
        logic [4:0] r5;
        logic [4:0] c5;
        r5 = r[4:0];
        c5 = c[4:0];
        w  = 0;
        while (!win_valid && w < 12) begin
            @(negedge clk);
            start = 1'b0;
            w++;
        end
        wait_cyc = w;
        chk("win_valid_timeout", 128'(win_valid), 128'(1));
        if (win_valid) begin
            chk("window", 128'({out_row, out_col, win_data}), 128'({r5, c5, exp_win(r, c)}));
            if (stall > 0) begin
                win_ready = 1'b0;
                for (int i = 0; i < stall; i++) begin
                    @(negedge clk);
                    chk("stall_hold", 128'({win_valid, out_row, out_col, win_data}),
                        128'({1'b1, r5, c5, exp_win(r, c)}));
                end
                win_ready = 1'b1;
            end
            @(negedge clk);
            chk("valid_deassert", 128'(win_valid), 128'(0));
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int er;
        int ec;
        int w;

        rst       = 1'b0;
        start     = 1'b0;
        win_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs_vec(), 128'(0));
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outputs", outs_vec(), 128'(0));
        end

        // Full sweep: back-pressure at (3,7), stray start at window 100.
        win_ready = 1'b1;
        pulse_start();
        chk("first_addr_k0", 128'({rd_addr1, rd_addr2, busy}), 128'({10'd0, 10'd1, 1'b1}));
        er = 0;
        ec = 0;
        for (int n = 0; n < 676; n++) begin
            accept_window(er, ec, (er == 3 && ec == 7) ? 10 : 0, w);
            if (er == 0 && ec < 2)
                chk("window_latency", 128'(w), 128'(5));
            if (n == 675) begin
                chk("last_pos", 128'({out_row, out_col}), 128'(0));
                chk("done_last", 128'({done, busy}), 128'({1'b1, 1'b0}));
            end else begin
                chk("done_mid", 128'({done, busy}), 128'({1'b0, 1'b1}));
            end
            if (n == 99)
                start = 1'b1;
            if (ec == COLS - 3) begin
                ec = 0;
                er++;
            end else begin
                ec++;
            end
        end
        chk("window_count_rows", 128'(er), 128'(ROWS - 2));
        chk("last_window_p8", 128'(win_data[71:64]), 128'(8'd15));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("after_done", 128'({done, busy, win_valid}), 128'(0));
        end

        // Reset during FETCH k=2 of window 50.
        pulse_start();
        er = 0;
        ec = 0;
        for (int n = 0; n < 50; n++) begin
            accept_window(er, ec, 0, w);
            if (ec == COLS - 3) begin
                ec = 0;
                er++;
            end else begin
                ec++;
            end
        end
        @(negedge clk);
        @(negedge clk);
        chk("addr_k2_win50", 128'({rd_addr1, rd_addr2}), 128'({exp_addr(1, 24, 4), exp_addr(1, 24, 5)}));
        rst = 1'b0;
        @(negedge clk);
        chk("midsweep_reset", outs_vec(), 128'(0));
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_reset_idle", outs_vec(), 128'(0));
        end
        pulse_start();
        chk("restart_addr_k0", 128'({rd_addr1, rd_addr2}), 128'({10'd0, 10'd1}));
        accept_window(0, 0, 0, w);
        chk("restart_latency", 128'(w), 128'(5));
        accept_window(0, 1, 0, w);
        chk("restart_period", 128'(w), 128'(5));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
